// File: rtl/matrix_framebuf_pkg.sv
// Shared geometry defaults, pixel-pair layout and sizing helpers for the framebuffer.
package matrix_framebuf_pkg;

  localparam int unsigned FB_WIDTH     = 32;
  localparam int unsigned FB_ADDR_BITS = 4;
  localparam int unsigned FB_DEPTH     = 2;

  // One beat toward the driver: bit 0 = upper-half pixel, bit 1 = lower-half pixel.
  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } px_pair_t;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned fb_clog2(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_fb_ram.sv
// Simple dual-port RAM: one write port, one registered read port that holds when re is low.
module matrix_fb_ram #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned ENTRIES = 1 << AW;

  logic [DW-1:0] mem [ENTRIES];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; output holds its value while re is low.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/matrix_framebuf.sv
// Double-buffered framebuffer with bit-plane scan sequencer feeding the HUB75 driver.
// Host writes go to the back bank; the scan streams pixel pairs from the front bank and
// the banks only exchange on the last beat of a frame.
module matrix_framebuf
  import matrix_framebuf_pkg::*;
#(
  parameter int unsigned WIDTH     = FB_WIDTH,
  parameter int unsigned ADDR_BITS = FB_ADDR_BITS,
  parameter int unsigned DEPTH     = FB_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [fb_clog2(WIDTH)-1:0]   wr_x,
  input  logic [ADDR_BITS:0]           wr_y,
  input  logic [3*DEPTH-1:0]           wr_rgb,
  input  logic                         swap_req,
  output logic                         swap_done,
  output logic                         px_valid,
  input  logic                         px_ready,
  output logic [1:0]                   px_r,
  output logic [1:0]                   px_g,
  output logic [1:0]                   px_b,
  output logic [ADDR_BITS-1:0]         px_row,
  output logic [fb_clog2(WIDTH)-1:0]   px_col,
  output logic [fb_clog2(DEPTH)-1:0]   px_plane,
  output logic                         px_last,
  output logic                         px_fend
);

  localparam int unsigned CW     = fb_clog2(WIDTH);
  localparam int unsigned PW     = fb_clog2(DEPTH);
  localparam int unsigned RGBW   = 3 * DEPTH;
  localparam int unsigned RAM_AW = ADDR_BITS + CW;

  logic [CW-1:0]        col_q;
  logic [PW-1:0]        plane_q;
  logic [ADDR_BITS-1:0] row_q;
  logic                 last_col_c;
  logic                 last_plane_c;
  logic                 last_row_c;
  logic                 advance_c;

  logic                 front_q;
  logic                 front_nxt_c;
  logic                 s1_bank_q;
  swap_state_e          state_q;
  swap_state_e          state_d;
  logic                 fend_xfer_c;
  logic                 swap_go_c;

  logic [RAM_AW-1:0]    wr_addr_c;
  logic [RAM_AW-1:0]    rd_addr_c;
  logic [RGBW-1:0]      rd_data [2][2];

  logic [DEPTH-1:0]     up_r_c, up_g_c, up_b_c;
  logic [DEPTH-1:0]     lo_r_c, lo_g_c, lo_b_c;
  px_pair_t             pair_c;

  assign last_col_c   = (col_q == CW'(WIDTH - 1));
  assign last_plane_c = (plane_q == PW'(DEPTH - 1));
  assign last_row_c   = &row_q;

  // The whole pipeline moves together: stage 1 empty or being drained.
  assign advance_c = ~px_valid | px_ready;

  // Stage 0: scan position (col fastest, then plane, then row) addressing the RAMs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q   <= '0;
      plane_q <= '0;
      row_q   <= '0;
    end else if (advance_c) begin
      col_q <= last_col_c ? '0 : col_q + CW'(1);
      if (last_col_c) begin
        plane_q <= last_plane_c ? '0 : plane_q + PW'(1);
        if (last_plane_c) row_q <= row_q + ADDR_BITS'(1);
      end
    end
  end

  // Stage 1: beat sideband registers, loaded alongside the RAM read registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      px_valid  <= 1'b0;
      px_row    <= '0;
      px_col    <= '0;
      px_plane  <= '0;
      px_last   <= 1'b0;
      px_fend   <= 1'b0;
      s1_bank_q <= 1'b0;
    end else if (advance_c) begin
      px_valid  <= 1'b1;
      px_row    <= row_q;
      px_col    <= col_q;
      px_plane  <= plane_q;
      px_last   <= last_col_c;
      px_fend   <= last_col_c & last_plane_c & last_row_c;
      s1_bank_q <= front_nxt_c;
    end
  end

  assign fend_xfer_c = px_valid & px_ready & px_fend;
  assign front_nxt_c = front_q ^ swap_go_c;
  assign swap_done   = rst & swap_go_c;

  // Swap state and bank-role register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SWAP_IDLE;
      front_q <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_nxt_c;
    end
  end

  // Swap next-state: a request waits for the frame-end transfer; repeats while pending merge.
  always_comb begin
    state_d   = state_q;
    swap_go_c = 1'b0;
    case (state_q)
      SWAP_IDLE: begin
        if (swap_req) begin
          if (fend_xfer_c) swap_go_c = 1'b1;
          else             state_d   = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        if (fend_xfer_c) begin
          swap_go_c = 1'b1;
          state_d   = SWAP_IDLE;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  assign wr_addr_c = {wr_y[ADDR_BITS-1:0], wr_x};
  assign rd_addr_c = {row_q, col_q};

  // Two banks x two panel halves; writes hit only the back bank, reads track the scan.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar h = 0; h < 2; h++) begin : g_half
      logic we_c;
      assign we_c = rst & wr_en & (wr_y[ADDR_BITS] == 1'(h)) & (front_q != 1'(b));
      matrix_fb_ram #(
        .AW (RAM_AW),
        .DW (RGBW)
      ) u_ram (
        .clk   (clk),
        .we    (we_c),
        .waddr (wr_addr_c),
        .wdata (wr_rgb),
        .re    (rst & advance_c),
        .raddr (rd_addr_c),
        .rdata (rd_data[b][h])
      );
    end
  end

  // Plane-bit select from the bank captured with the beat; zero while no beat is held.
  always_comb begin
    {up_r_c, up_g_c, up_b_c} = rd_data[s1_bank_q][0];
    {lo_r_c, lo_g_c, lo_b_c} = rd_data[s1_bank_q][1];
    pair_c = '0;
    if (px_valid) begin
      pair_c.r = {lo_r_c[px_plane], up_r_c[px_plane]};
      pair_c.g = {lo_g_c[px_plane], up_g_c[px_plane]};
      pair_c.b = {lo_b_c[px_plane], up_b_c[px_plane]};
    end
  end

  assign px_r = pair_c.r;
  assign px_g = pair_c.g;
  assign px_b = pair_c.b;

endmodule

// File: tb/tb_matrix_framebuf.sv
// Randomised bench for matrix_framebuf against a frame-level model of banks, scan order and swaps.
module tb_matrix_framebuf;

  logic       clk = 1'b0;
  logic       rst, wr_en, swap_req, swap_done, px_valid, px_ready, px_last, px_fend;
  logic [4:0] wr_x, wr_y, px_col;
  logic [5:0] wr_rgb;
  logic [1:0] px_r, px_g, px_b;
  logic [3:0] px_row;
  logic [0:0] px_plane;

  matrix_framebuf dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_rgb    (wr_rgb),
    .swap_req  (swap_req),
    .swap_done (swap_done),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .px_r      (px_r),
    .px_g      (px_g),
    .px_b      (px_b),
    .px_row    (px_row),
    .px_col    (px_col),
    .px_plane  (px_plane),
    .px_last   (px_last),
    .px_fend   (px_fend)
  );

  always #5 clk = ~clk;

  // Model: two banks of 32x32 pixels indexed [bank][panel y][x], plus which pixels are known.
  logic [5:0]  mb    [2][32][32];
  bit          wrote [2][32][32];
  int          m_front, m_idx, since;
  bit          m_pend;
  int          errors = 0;
  int          checks = 0;
  bit          hold_v;
  logic [18:0] hold_snap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, check outputs, then advance the model at the rising edge.
  task automatic step(input bit rdy, input bit sreq, input bit we, input int x, input int y,
                      input logic [5:0] rgb);
    logic [18:0] snap;
    logic [5:0]  up, lo, e;
    bit          fire, go;
    int          ec, ep, er;
    px_ready = rdy;
    swap_req = sreq;
    wr_en    = we;
    wr_x     = 5'(x);
    wr_y     = 5'(y);
    wr_rgb   = rgb;
    #1;
    snap = {px_valid, px_r, px_g, px_b, px_row, px_col, px_plane, px_last, px_fend};
    if (since == 0) check("reset_outs", 32'({snap, swap_done}), 32'd0);
    if (since >= 2) check("valid_up", 32'(px_valid), 32'd1);
    if (hold_v)     check("stall_hold", 32'(snap), 32'(hold_snap));
    fire = rst && px_valid && rdy;
    go   = fire && (m_idx == 1023) && (m_pend || sreq);
    if (since >= 0) check("swap_done", 32'(swap_done), 32'(go));
    if (fire) begin
      ec = m_idx % 32;
      ep = (m_idx / 32) % 2;
      er = m_idx / 64;
      check("beat_pos", 32'({px_row, px_col, px_plane}), 32'({4'(er), 5'(ec), 1'(ep)}));
      check("beat_last", 32'(px_last), 32'(ec == 31));
      check("beat_fend", 32'(px_fend), 32'(m_idx == 1023));
      if (wrote[m_front][er][ec] && wrote[m_front][er+16][ec]) begin
        up = mb[m_front][er][ec];
        lo = mb[m_front][er+16][ec];
        e  = {lo[4+ep], up[4+ep], lo[2+ep], up[2+ep], lo[ep], up[ep]};
        check("beat_rgb", 32'({px_r, px_g, px_b}), 32'(e));
      end
    end
    hold_v    = rst && px_valid && !rdy;
    hold_snap = snap;
    @(posedge clk);
    if (!rst) begin
      m_front = 0;
      m_pend  = 0;
      m_idx   = 0;
      since   = 0;
      hold_v  = 0;
    end else begin
      if (we) begin
        mb[1-m_front][y][x]    = rgb;
        wrote[1-m_front][y][x] = 1'b1;
      end
      if (go)        begin m_front = 1 - m_front; m_pend = 0; end
      else if (sreq) m_pend = 1;
      if (fire)      m_idx = (m_idx + 1) % 1024;
      if (since >= 0) since++;
    end
    @(negedge clk);
  endtask

  // On a swap edge the first read of the new frame (x=0, row 0, both halves) comes from the bank
  // being written, so random writes stay off that address.
  task automatic rnd_step(input int rdy_pct, input int wr_pct, input int sreq_pm);
    int x, y;
    x = int'($urandom_range(31));
    y = int'($urandom_range(31));
    if (x == 0 && (y % 16) == 0) x = 1;
    step($urandom_range(99) < rdy_pct, $urandom_range(999) < sreq_pm,
         $urandom_range(99) < wr_pct, x, y, 6'($urandom));
  endtask

  // Write every pixel of the current back bank with random colours (no swap may be pending).
  task automatic fill_back();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        step(1'b1, 1'b0, 1'b1, x, y, 6'($urandom));
  endtask

  // Stream with ready=1 until the frame-end beat is presented (bounded).
  task automatic run_to_fend();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2200; i++) begin
      if (px_valid && px_fend) begin
        ok = 1'b1;
        break;
      end
      step(1'b1, 1'b0, 1'b0, 1, 1, 6'd0);
    end
    check("fend_reached", 32'(ok), 32'd1);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; swap_req = 1'b0; px_ready = 1'b0;
    wr_x = '0; wr_y = '0; wr_rgb = '0;
    m_front = 0; m_idx = 0; m_pend = 0; since = -1; hold_v = 0;
    @(negedge clk);

    // Reset with a write and a swap request presented; both must vanish.
    step(1'b1, 1'b1, 1'b1, 4, 4, 6'h2a);
    step(1'b1, 1'b0, 1'b0, 0, 0, 6'd0);
    step(1'b0, 1'b0, 0, 0, 0, 6'd0);
    rst = 1'b1;

    // Full-rate stream from reset while bank 1 is filled; covers first frame and its end.
    fill_back();
    repeat (40) step(1'b1, 1'b0, 1'b0, 1, 1, 6'd0);

    // Directed pixel pair at column 3 row 5, then a mid-frame swap with a merged second request.
    step(1'b1, 1'b0, 1'b1, 3, 5, 6'b11_01_10);
    step(1'b1, 1'b0, 1'b1, 3, 21, 6'b01_00_11);
    repeat (300) step(1'b1, 1'b0, 1'b0, 1, 1, 6'd0);
    step(1'b1, 1'b1, 1'b0, 1, 1, 6'd0);
    repeat (50) step(1'b1, 1'b0, 1'b0, 1, 1, 6'd0);
    step(1'b1, 1'b1, 1'b0, 1, 1, 6'd0);
    run_to_fend();
    step(1'b1, 1'b0, 1'b0, 1, 1, 6'd0);
    fill_back();

    // Random backpressure, writes and occasional swap requests.
    repeat (6000) rnd_step(50, 30, 3);

    // Swap request coincident with the frame-end transfer, writing into the bank turning front.
    if (m_pend) begin
      run_to_fend();
      step(1'b1, 1'b0, 1'b0, 1, 1, 6'd0);
    end
    run_to_fend();
    step(1'b1, 1'b1, 1'b1, 7, 9, 6'($urandom));
    repeat (1100) rnd_step(100, 0, 0);

    // One-cycle reset mid-row with bank 1 in front; the write presented in that cycle is dropped.
    if (m_front == 0) begin
      step(1'b1, 1'b1, 1'b0, 1, 1, 6'd0);
      run_to_fend();
      step(1'b1, 1'b0, 1'b0, 1, 1, 6'd0);
    end
    repeat (200) step(1'b1, 1'b0, 1'b0, 1, 1, 6'd0);
    for (int i = 0; i < 64 && px_col != 5'd10; i++) step(1'b1, 1'b0, 1'b0, 1, 1, 6'd0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b1, 9, 3, 6'($urandom));
    rst = 1'b1;
    repeat (1100) rnd_step(70, 20, 0);
    step(1'b1, 1'b1, 1'b0, 1, 1, 6'd0);
    repeat (2400) rnd_step(60, 20, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
